// File: rtl/axi_stream_protocol_checker.sv
// axi_stream_protocol_checker: passive AXI-Stream link checker with sticky errors and saturating stats
// Define AXIS_CHECKER_TIMEOUT_EN to add the TREADY stall watchdog on err[5].
module axi_stream_protocol_checker #(
    parameter int byte_width     = 4,
    parameter int id_width       = 0,
    parameter int dest_width     = 0,
    parameter int user_width     = 0,
    parameter int cnt_width      = 32,
    parameter int no_interleave  = 1,
    parameter int timeout_cycles = 1024
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                clear,
    input  logic                                tvalid,
    input  logic                                tready,
    input  logic                                tlast,
    input  logic [8*byte_width-1:0]             tdata,
    input  logic [byte_width-1:0]               tstrb,
    input  logic [byte_width-1:0]               tkeep,
    input  logic [(id_width>0?id_width:1)-1:0]     tid,
    input  logic [(dest_width>0?dest_width:1)-1:0] tdest,
    input  logic [(user_width>0?user_width:1)-1:0] tuser,
    output logic [5:0]                          err,
    output logic                                err_any,
    output logic [2:0]                          first_err,
    output logic [cnt_width-1:0]                first_err_beat,
    output logic                                in_packet,
    output logic [cnt_width-1:0]                beat_count,
    output logic [cnt_width-1:0]                packet_count,
    output logic [cnt_width-1:0]                byte_count
);
    localparam int IW = id_width > 0 ? id_width : 1;
    localparam int DW = dest_width > 0 ? dest_width : 1;
    localparam int UW = user_width > 0 ? user_width : 1;

    logic                    hs, stall_q, post_reset_q, payload_diff, ileave, timeout_hit;
    logic [8*byte_width-1:0] snap_data;
    logic [byte_width-1:0]   snap_strb, snap_keep;
    logic                    snap_last;
    logic [IW-1:0]           snap_id, pkt_id;
    logic [DW-1:0]           snap_dest, pkt_dest;
    logic [UW-1:0]           snap_user;
    logic [5:0]              v;
    logic [2:0]              v_idx;
    logic [cnt_width:0]      keep_cnt, byte_sum;
    logic [cnt_width-1:0]    beat_nx, pkt_nx, byte_nx;

    assign hs = tvalid && tready;

    // Absent sideband fields are masked out by the width tests, which fold to constants.
    assign payload_diff = tdata != snap_data || tstrb != snap_strb || tkeep != snap_keep ||
                          tlast != snap_last ||
                          (id_width > 0 && tid != snap_id) ||
                          (dest_width > 0 && tdest != snap_dest) ||
                          (user_width > 0 && tuser != snap_user);
    assign ileave = no_interleave != 0 && hs && in_packet &&
                    ((id_width > 0 && tid != pkt_id) || (dest_width > 0 && tdest != pkt_dest));

    assign v = {timeout_hit, ileave, tvalid && |(tstrb & ~tkeep), !post_reset_q && tvalid,
                stall_q && tvalid && payload_diff, stall_q && !tvalid};
    assign v_idx = v[0] ? 3'd0 : v[1] ? 3'd1 : v[2] ? 3'd2 : v[3] ? 3'd3 :
                   v[4] ? 3'd4 : v[5] ? 3'd5 : 3'd0;
    assign err_any = |err;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < byte_width; i++) keep_cnt = keep_cnt + {{cnt_width{1'b0}}, tkeep[i]};
    end

    assign byte_sum = {1'b0, byte_count} + keep_cnt;
    assign byte_nx  = byte_sum[cnt_width] ? '1 : byte_sum[cnt_width-1:0];
    assign beat_nx  = &beat_count ? beat_count : beat_count + cnt_width'(1);
    assign pkt_nx   = &packet_count ? packet_count : packet_count + cnt_width'(1);

`ifdef AXIS_CHECKER_TIMEOUT_EN
    localparam int SW = $clog2(timeout_cycles + 1);
    logic [SW-1:0] stall_cnt;

    // Counter parks at the limit so the watchdog fires exactly once per stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_cnt <= '0;
        else if (tvalid && !tready) stall_cnt <= stall_cnt == SW'(timeout_cycles) ? stall_cnt : stall_cnt + SW'(1);
        else stall_cnt <= '0;
    end

    assign timeout_hit = tvalid && !tready && stall_cnt == SW'(timeout_cycles - 1);
`else
    localparam int unused_timeout = timeout_cycles;
    assign timeout_hit = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{tid, tdest, tuser};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q        <= 1'b0;
            post_reset_q   <= 1'b0;
            snap_data      <= '0;
            snap_strb      <= '0;
            snap_keep      <= '0;
            snap_last      <= 1'b0;
            snap_id        <= '0;
            snap_dest      <= '0;
            snap_user      <= '0;
            pkt_id         <= '0;
            pkt_dest       <= '0;
            in_packet      <= 1'b0;
            err            <= '0;
            first_err      <= '0;
            first_err_beat <= '0;
            beat_count     <= '0;
            packet_count   <= '0;
            byte_count     <= '0;
        end else begin
            stall_q      <= tvalid && !tready;
            post_reset_q <= 1'b1;
            snap_data    <= tdata;
            snap_strb    <= tstrb;
            snap_keep    <= tkeep;
            snap_last    <= tlast;
            snap_id      <= tid;
            snap_dest    <= tdest;
            snap_user    <= tuser;
            if (hs) in_packet <= !tlast;
            if (hs && !in_packet) begin
                pkt_id   <= tid;
                pkt_dest <= tdest;
            end
            if (clear) begin
                err            <= v;
                first_err      <= v_idx;
                first_err_beat <= '0;
                beat_count     <= '0;
                packet_count   <= '0;
                byte_count     <= '0;
            end else begin
                err <= err | v;
                if (!err_any && |v) begin
                    first_err      <= v_idx;
                    first_err_beat <= beat_count;
                end
                if (hs) begin
                    beat_count <= beat_nx;
                    byte_count <= byte_nx;
                    if (tlast) packet_count <= pkt_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// tb_axi_stream_protocol_checker: directed self-checking bench for axi_stream_protocol_checker
module tb_axi_stream_protocol_checker;
    logic        clk = 1'b0, resetn = 1'b0, clear = 1'b0;
    logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = 4'hF, tkeep = 4'hF;
    logic [1:0]  tid = '0;
    logic        tdest = 1'b0, tuser = 1'b0;
    logic [5:0]  err;
    logic        err_any, in_packet;
    logic [2:0]  first_err;
    logic [31:0] first_err_beat, beat_count, packet_count, byte_count;
    int checks = 0, failures = 0;

    axi_stream_protocol_checker #(
        .byte_width(4), .id_width(2), .dest_width(0), .user_width(0),
        .cnt_width(32), .no_interleave(1), .timeout_cycles(8)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .tvalid(tvalid), .tready(tready), .tlast(tlast), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tid(tid), .tdest(tdest), .tuser(tuser),
        .err(err), .err_any(err_any), .first_err(first_err), .first_err_beat(first_err_beat),
        .in_packet(in_packet), .beat_count(beat_count), .packet_count(packet_count),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clear();
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tstrb = 4'hF; tkeep = 4'hF; tid = 2'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        tick();
        checks++;
        if (err !== 6'd0 || beat_count !== 32'd0 || in_packet !== 1'b0) begin
            failures++; $display("FAIL reset_hold err=%b beats=%0d inpkt=%b want 0", err, beat_count, in_packet);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (err !== 6'b000100 || err_any !== 1'b1) begin
            failures++; $display("FAIL reset_valid err=%b any=%b want 000100/1", err, err_any);
        end
        checks++;
        if (first_err !== 3'd2 || first_err_beat !== 32'd0) begin
            failures++; $display("FAIL reset_first first=%0d beat=%0d want 2/0", first_err, first_err_beat);
        end
        idle_clear();
        checks++;
        if (err !== 6'd0 || beat_count !== 32'd0 || byte_count !== 32'd0 || first_err !== 3'd0) begin
            failures++; $display("FAIL reset_clear err=%b beats=%0d bytes=%0d first=%0d want 0", err, beat_count, byte_count, first_err);
        end
    endtask

    task automatic test_stream();
        tvalid = 1'b1; tready = 1'b1; tkeep = 4'hF; tstrb = 4'hF;
        for (int b = 1; b <= 3; b++) begin
            tdata = 32'h100 + b; tlast = (b == 3);
            tick();
            checks++;
            if (in_packet !== (b != 3)) begin
                failures++; $display("FAIL stream_inpkt beat=%0d got=%b want=%b", b, in_packet, b != 3);
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
        tick();
        checks++;
        if (beat_count !== 32'd3 || byte_count !== 32'd12 || packet_count !== 32'd1 || err !== 6'd0) begin
            failures++; $display("FAIL stream_counts beats=%0d bytes=%0d pkts=%0d err=%b want 3/12/1/0", beat_count, byte_count, packet_count, err);
        end
    endtask

    task automatic test_payload();
        tvalid = 1'b1; tready = 1'b0; tdata = 32'hA5;
        tick();
        checks++;
        if (err !== 6'd0) begin
            failures++; $display("FAIL payload_first_stall err=%b want 0", err);
        end
        tdata = 32'h5A;
        tick();
        checks++;
        if (err !== 6'b000010 || first_err !== 3'd1 || first_err_beat !== 32'd3) begin
            failures++; $display("FAIL payload_change err=%b first=%0d beat=%0d want 000010/1/3", err, first_err, first_err_beat);
        end
        tvalid = 1'b0;
        tick();
        checks++;
        if (err !== 6'b000011 || first_err !== 3'd1) begin
            failures++; $display("FAIL valid_drop err=%b first=%0d want 000011/1", err, first_err);
        end
        idle_clear();
        checks++;
        if (err !== 6'd0 || err_any !== 1'b0) begin
            failures++; $display("FAIL payload_clear err=%b any=%b want 0", err, err_any);
        end
    endtask

    task automatic test_strb_keep();
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1; tkeep = 4'b0011; tstrb = 4'b0100;
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        checks++;
        if (err !== 6'b001000 || first_err !== 3'd3) begin
            failures++; $display("FAIL strb_keep err=%b first=%0d want 001000/3", err, first_err);
        end
        checks++;
        if (beat_count !== 32'd1 || byte_count !== 32'd2 || packet_count !== 32'd1) begin
            failures++; $display("FAIL strb_counts beats=%0d bytes=%0d pkts=%0d want 1/2/1", beat_count, byte_count, packet_count);
        end
        idle_clear();
    endtask

    task automatic test_interleave();
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b0; tid = 2'd1;
        tick();
        checks++;
        if (err !== 6'd0 || in_packet !== 1'b1) begin
            failures++; $display("FAIL ileave_first err=%b inpkt=%b want 0/1", err, in_packet);
        end
        tid = 2'd2;
        tick();
        checks++;
        if (err !== 6'b010000 || first_err !== 3'd4 || first_err_beat !== 32'd1) begin
            failures++; $display("FAIL ileave err=%b first=%0d beat=%0d want 010000/4/1", err, first_err, first_err_beat);
        end
        idle_clear();
        checks++;
        if (err !== 6'd0 || beat_count !== 32'd0 || byte_count !== 32'd0 || in_packet !== 1'b1) begin
            failures++; $display("FAIL ileave_clear err=%b beats=%0d bytes=%0d inpkt=%b want 0/0/0/1", err, beat_count, byte_count, in_packet);
        end
    endtask

    task automatic test_clear_new_violation();
        clear = 1'b1; tvalid = 1'b1; tready = 1'b1; tlast = 1'b1; tid = 2'd1;
        tkeep = 4'b0011; tstrb = 4'b0100;
        tick();
        clear = 1'b0;
        checks++;
        if (err !== 6'b001000 || first_err !== 3'd3) begin
            failures++; $display("FAIL clear_wins err=%b first=%0d want 001000/3", err, first_err);
        end
        checks++;
        if (beat_count !== 32'd0 || byte_count !== 32'd0 || in_packet !== 1'b0) begin
            failures++; $display("FAIL clear_drop beats=%0d bytes=%0d inpkt=%b want 0/0/0", beat_count, byte_count, in_packet);
        end
        idle_clear();
    endtask

    task automatic test_timeout();
        tvalid = 1'b1; tready = 1'b0; tdata = 32'h77;
        for (int c = 1; c <= 7; c++) tick();
        checks++;
        if (err !== 6'd0) begin
            failures++; $display("FAIL timeout_early err=%b want 0", err);
        end
        tick();
`ifdef AXIS_CHECKER_TIMEOUT_EN
        checks++;
        if (err !== 6'b100000 || first_err !== 3'd5) begin
            failures++; $display("FAIL timeout err=%b first=%0d want 100000/5", err, first_err);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        checks++;
        if (err !== 6'd0) begin
            failures++; $display("FAIL timeout_once err=%b want 0", err);
        end
`else
        tick();
        checks++;
        if (err !== 6'd0) begin
            failures++; $display("FAIL timeout_off err=%b want 0", err);
        end
`endif
        tready = 1'b1; tlast = 1'b1;
        tick();
        idle_clear();
    endtask

    task automatic test_reset_mid_packet();
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
        tick();
        tvalid = 1'b0;
        checks++;
        if (in_packet !== 1'b1) begin
            failures++; $display("FAIL midpkt_open inpkt=%b want 1", in_packet);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (in_packet !== 1'b0 || beat_count !== 32'd0) begin
            failures++; $display("FAIL midpkt_async inpkt=%b beats=%0d want 0/0", in_packet, beat_count);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        checks++;
        if (err !== 6'd0 || in_packet !== 1'b0) begin
            failures++; $display("FAIL midpkt_after err=%b inpkt=%b want 0/0", err, in_packet);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_payload();
        test_strb_keep();
        test_interleave();
        test_clear_new_violation();
        test_timeout();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
